// File: rtl/kasumi_pkg.sv
// Shared definitions for the Kasumi core.
// Default register-file geometry and address type.
package kasumi_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO  = 0;

  typedef logic [$clog2(NREGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_rdport.sv
// One register-file read port: address mux, x0 forcing and optional bypass.
// Bypass is compiled in when REG_FILE_BYPASS_EN is defined.
module reg_file_rdport
  import kasumi_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] regs [NREGS],
  input  logic [NREGS-1:0] pend,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] data,
  output logic            busy
);

`ifndef REG_FILE_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_addr, wb_data};
`endif

  // Stored value, overridden for x0 and (optionally) an in-flight write-back.
  always_comb begin
    data = regs[addr];
    busy = pend[addr];
    if (addr == AW'(REG_ZERO)) begin
      data = '0;
      busy = 1'b0;
    end
`ifdef REG_FILE_BYPASS_EN
    else if (wb_valid && wb_addr == addr) begin
      data = wb_data;
      busy = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with write-pending scoreboard and debug port.
// Optional same-cycle write-back bypass: define REG_FILE_BYPASS_EN.
module reg_file_sb
  import kasumi_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic              claim_valid,
  input  logic [AW-1:0]     claim_addr,
  output logic              claim_ready,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [AW-1:0]     dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             wb_hit;
  logic             claim_fire;

  assign wb_hit = wb_valid && (wb_addr != AW'(REG_ZERO));

  // A retiring write-back to the same register frees it this cycle.
  assign claim_ready = (claim_addr == AW'(REG_ZERO))
                    || !busy[claim_addr]
                    || (wb_valid && wb_addr == claim_addr);

  assign claim_fire = claim_valid && claim_ready
                   && (claim_addr != AW'(REG_ZERO));

  assign dbg_data = regs[dbg_addr];

  // Architectural state; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Scoreboard: write-back clears, claim sets; claim wins on a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (wb_hit) busy[wb_addr] <= 1'b0;
      if (claim_fire) busy[claim_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    reg_file_rdport #(
      .XLEN (XLEN),
      .NREGS(NREGS),
      .AW   (AW)
    ) u_rd (
      .addr    (rd_addr[k*AW +: AW]),
      .regs    (regs),
      .pend    (busy),
      .wb_valid(wb_valid),
      .wb_addr (wb_addr),
      .wb_data (wb_data),
      .data    (rd_data[k*XLEN +: XLEN]),
      .busy    (rd_busy[k])
    );
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: default build plus a 64x16x4 build.
// Expected values are queued when stimulus is applied and popped on check.
module tb_reg_file_sb;

  logic        clk;
  logic        rst_n;

  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        claim_valid;
  logic [4:0]  claim_addr;
  logic        claim_ready;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic [15:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic         b_claim_valid;
  logic [3:0]   b_claim_addr;
  logic         b_claim_ready;
  logic         b_wb_valid;
  logic [3:0]   b_wb_addr;
  logic [63:0]  b_wb_data;
  logic [3:0]   b_dbg_addr;
  logic [63:0]  b_dbg_data;

  int tests;
  int failed;

  logic [63:0] exp_q [$];
  string       tag_q [$];

  reg_file_sb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .claim_valid(claim_valid),
    .claim_addr (claim_addr),
    .claim_ready(claim_ready),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  reg_file_sb #(
    .XLEN (64),
    .NREGS(16),
    .NRD  (4)
  ) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (b_rd_addr),
    .rd_data    (b_rd_data),
    .rd_busy    (b_rd_busy),
    .claim_valid(b_claim_valid),
    .claim_addr (b_claim_addr),
    .claim_ready(b_claim_ready),
    .wb_valid   (b_wb_valid),
    .wb_addr    (b_wb_addr),
    .wb_data    (b_wb_data),
    .dbg_addr   (b_dbg_addr),
    .dbg_data   (b_dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string t, input logic [63:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failed++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    logic [31:0] lo;
    lo = (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
    return {8'(i), 24'hC0FFEE, lo};
  endfunction

  initial begin
    int sets [3][4];
    sets = '{'{1, 2, 3, 4}, '{15, 8, 4, 11}, '{7, 0, 13, 6}};
    tests = 0;
    failed = 0;
    rst_n = 1'b0;
    rd_addr = '0;
    claim_valid = 1'b0;
    claim_addr = '0;
    wb_valid = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    dbg_addr = '0;
    b_rd_addr = '0;
    b_claim_valid = 1'b0;
    b_claim_addr = '0;
    b_wb_valid = 1'b0;
    b_wb_addr = '0;
    b_wb_data = '0;
    b_dbg_addr = '0;

    #3;
    expect_val("reset_rd_data", 64'h0);
    check(rd_data);
    expect_val("reset_rd_busy", 64'h0);
    check(64'(rd_busy));
    expect_val("reset_claim_ready", 64'h1);
    check(64'(claim_ready));

    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Load x5 and claim x9, then pulse reset between edges.
    wb_valid = 1'b1;
    wb_addr = 5'd5;
    wb_data = 32'hDEADBEEF;
    claim_valid = 1'b1;
    claim_addr = 5'd9;
    tick();
    wb_valid = 1'b0;
    claim_valid = 1'b0;
    rd_addr = {5'd9, 5'd5};
    #1;
    expect_val("x5_loaded", 64'hDEADBEEF);
    check(64'(rd_data[31:0]));
    expect_val("x9_claimed_busy", 64'h1);
    check(64'(rd_busy[1]));
    #2;
    rst_n = 1'b0;
    #1;
    expect_val("async_reset_x5", 64'h0);
    check(64'(rd_data[31:0]));
    expect_val("async_reset_busy", 64'h0);
    check(64'(rd_busy));
    #2;
    rst_n = 1'b1;
    tick();

    // Write x3, read on both ports and debug.
    wb_valid = 1'b1;
    wb_addr = 5'd3;
    wb_data = 32'h1234_5678;
    tick();
    wb_valid = 1'b0;
    rd_addr = {5'd3, 5'd3};
    dbg_addr = 5'd3;
    #1;
    expect_val("x3_port0", 64'h12345678);
    check(64'(rd_data[31:0]));
    expect_val("x3_port1", 64'h12345678);
    check(64'(rd_data[63:32]));
    expect_val("x3_dbg", 64'h12345678);
    check(64'(dbg_data));
    expect_val("x3_not_busy", 64'h0);
    check(64'(rd_busy));

    // Write to x0 is ignored.
    wb_valid = 1'b1;
    wb_addr = 5'd0;
    wb_data = 32'hFFFF_FFFF;
    tick();
    wb_valid = 1'b0;
    rd_addr = {5'd3, 5'd0};
    dbg_addr = 5'd0;
    #1;
    expect_val("x0_read", 64'h0);
    check(64'(rd_data[31:0]));
    expect_val("x0_dbg", 64'h0);
    check(64'(dbg_data));

    // Claim x7 twice; the second is refused.
    claim_valid = 1'b1;
    claim_addr = 5'd7;
    #1;
    expect_val("claim1_ready", 64'h1);
    check(64'(claim_ready));
    tick();
    rd_addr = {5'd3, 5'd7};
    #1;
    expect_val("claim2_ready", 64'h0);
    check(64'(claim_ready));
    expect_val("x7_busy", 64'h1);
    check(64'(rd_busy[0]));
    tick();
    expect_val("held_claim_busy", 64'h1);
    check(64'(rd_busy[0]));

    // Write-back x7 with a concurrent claim: claim wins.
    wb_valid = 1'b1;
    wb_addr = 5'd7;
    wb_data = 32'h0000_00A5;
    #1;
    expect_val("claim_wb_ready", 64'h1);
    check(64'(claim_ready));
    tick();
    wb_valid = 1'b0;
    claim_valid = 1'b0;
    #1;
    expect_val("x7_busy_after", 64'h1);
    check(64'(rd_busy[0]));
    expect_val("x7_data", 64'hA5);
    check(64'(rd_data[31:0]));

    // x10 = 0x11, claim it, then write-back 0x55 while port 1 reads.
    wb_valid = 1'b1;
    wb_addr = 5'd10;
    wb_data = 32'h11;
    tick();
    wb_valid = 1'b0;
    claim_valid = 1'b1;
    claim_addr = 5'd10;
    tick();
    claim_valid = 1'b0;
    rd_addr = {5'd10, 5'd7};
    wb_valid = 1'b1;
    wb_addr = 5'd10;
    wb_data = 32'h55;
    #1;
`ifdef REG_FILE_BYPASS_EN
    expect_val("bypass_data", 64'h55);
    check(64'(rd_data[63:32]));
    expect_val("bypass_busy", 64'h0);
    check(64'(rd_busy[1]));
`else
    expect_val("nobypass_data", 64'h11);
    check(64'(rd_data[63:32]));
    expect_val("nobypass_busy", 64'h1);
    check(64'(rd_busy[1]));
`endif
    tick();
    wb_valid = 1'b0;
    #1;
    expect_val("x10_after_wb", 64'h55);
    check(64'(rd_data[63:32]));
    expect_val("x10_free", 64'h0);
    check(64'(rd_busy[1]));

    // Claim x0 together with write-back x0: nothing changes.
    claim_valid = 1'b1;
    claim_addr = 5'd0;
    wb_valid = 1'b1;
    wb_addr = 5'd0;
    wb_data = 32'hFFFF_FFFF;
    #1;
    expect_val("claim_x0_ready", 64'h1);
    check(64'(claim_ready));
    tick();
    claim_valid = 1'b0;
    wb_valid = 1'b0;
    rd_addr = {5'd7, 5'd0};
    dbg_addr = 5'd10;
    #1;
    expect_val("x0_still_zero", 64'h0);
    check(64'(rd_data[31:0]));
    expect_val("busy_after_x0", 64'h2);
    check(64'(rd_busy));
    expect_val("x7_kept", 64'hA5);
    check(64'(rd_data[63:32]));
    expect_val("x10_dbg", 64'h55);
    check(64'(dbg_data));

    // Wide build: distinct patterns in x1..x15, read four at once.
    for (int i = 1; i < 16; i++) begin
      b_wb_valid = 1'b1;
      b_wb_addr = 4'(i);
      b_wb_data = pat(i);
      tick();
    end
    b_wb_valid = 1'b0;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 4; k++) b_rd_addr[k*4 +: 4] = 4'(sets[s][k]);
      b_dbg_addr = 4'(sets[s][0]);
      #1;
      for (int k = 0; k < 4; k++) begin
        expect_val($sformatf("wide_s%0d_p%0d", s, k),
                   sets[s][k] == 0 ? 64'h0 : pat(sets[s][k]));
        check(b_rd_data[k*64 +: 64]);
      end
      expect_val($sformatf("wide_s%0d_dbg", s), pat(sets[s][0]));
      check(b_dbg_data);
      expect_val($sformatf("wide_s%0d_busy", s), 64'h0);
      check(64'(b_rd_busy));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
